led_trail_pwm: RTL
==================

LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

Interface
REQ-001 The block SHALL have parameter DECAY_TICKS, default 32'd_1_000_000, giving the clock cycles between brightness decay steps (legal range 1 to 2^32-1).
REQ-002 The block SHALL have parameter DECAY_STEP, default 8'd32, giving the brightness decrement per decay step (legal range 1 to 255).
REQ-003 clock  input  1  single system clock; all logic SHALL be on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 leds_in  input  8  one-hot scan pattern from the LED scanner; bit i high means LED i is the active scan position; treated as asynchronous.
REQ-006 leds  output  8  PWM-modulated LED drive; bit i high means LED i is lit.

Function
REQ-007 Each leds_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-008 The block SHALL keep one 8-bit brightness register per LED, bright[i], with 0 meaning off and 255 meaning full brightness.
REQ-009 A prescaler SHALL count 0..DECAY_TICKS-1 and wrap to 0, pulsing decay_tick for exactly one cycle when the count equals DECAY_TICKS-1.
REQ-010 bright[i] update priority:
  - synced bit i high -> load 255;
  - else, on decay_tick -> (bright[i] > DECAY_STEP) ? bright[i]-DECAY_STEP : 0, saturating at 0 with no wrap;
  - else -> hold.
REQ-011 If a synced bit is high in the same cycle as decay_tick, the load of 255 SHALL win.
REQ-012 An 8-bit PWM counter SHALL count 0..254 and wrap to 0, giving a period of 255 cycles.
REQ-013 leds[i] SHALL be a registered output equal to (bright[i] > pwm_cnt), so brightness 255 is lit every cycle, 0 is never lit, and brightness B is lit B cycles per period.
REQ-014 Latency: when leds_in[i] rises and is sampled at edge k, bright[i] SHALL be 255 after edge k+2 and leds[i] SHALL be high after edge k+3.
REQ-015 After leds_in[i] falls, LED i SHALL keep full brightness until the next decay_tick, then dim by DECAY_STEP per tick, reaching 0 after ceil(255/DECAY_STEP) ticks.
REQ-016 Multiple leds_in bits high at once SHALL each be handled independently; no one-hot check is required.
REQ-017 The prescaler and the PWM counter SHALL free-run, independent of leds_in.

Reset
REQ-018 While reset is high, the synchronizer flops, all bright[i], the prescaler, pwm_cnt and leds SHALL all be 0, asynchronously.
REQ-019 Reset asserted mid-fade SHALL clear all trails at once; after reset release, the first decay_tick SHALL come exactly DECAY_TICKS cycles later.
REQ-020 Reset deassertion does not need to be synchronized inside this block; that is the top-level reset synchronizer's job.

Structure
REQ-021 Shared package leds_pkg SHALL hold LED_COUNT=8, BRIGHT_BITS=8, BRIGHT_MAX=8'd255 and PWM_MAX=8'd254.
REQ-022 Sub-module led_pwm_channel SHALL hold one bright register, the decay/load logic and the compare-output flop; the top SHALL instantiate it LED_COUNT times via generate, and the prescaler, PWM counter and synchronizer SHALL stay in the top.
REQ-023 The design SHALL contain no latches, no derived or gated clocks, and no combinational paths from input to output.

Verification (DECAY_TICKS=4, DECAY_STEP=64 unless noted)
REQ-024 Reset: hold reset with leds_in=8'hFF -> leds=8'h00 and bright[*]=0 throughout; release reset -> leds[7:0] all high 3 edges later.
REQ-025 Latency: leds_in 8'h00 -> 8'h01 sampled at edge k -> leds[0]=1 after edge k+3 and high on every cycle while the input is held.
REQ-026 Decay: leds_in bit 3 high then low -> bright[3] sequence 255, 191, 127, 63, 0, changing only on decay_tick, with no underflow; leds[3] duty over each PWM period equals 191/255, 127/255, 63/255 and 0 respectively.
REQ-027 Collision: set leds_in[5] high in the exact cycle decay_tick fires -> bright[5]=255, not 191.
REQ-028 Reset mid-fade: assert reset while bright[2]=127 -> leds=0 immediately (combinationally from reset); after release, first decay_tick comes 4 cycles later.
REQ-029 Scanner stream: apply a 1,2,4,...,128,64,...,1 one-hot sequence, 8 cycles per step, DECAY_STEP=32 -> after each step, every bright[i] equals 255 minus 32 times the decay ticks since LED i was last active, floored at 0; full PWM duty compare checked by a scoreboard.

Source files
------------

// File: rtl/leds_pkg.sv
// Shared constants for the LED trail PWM block.
//   LED_COUNT   : number of LED channels
//   BRIGHT_BITS : width of each brightness register
//   BRIGHT_MAX  : brightness loaded while an LED is the active scan position
//   PWM_MAX     : last PWM count before wrapping, giving a 255-cycle period
package leds_pkg;
    localparam int                   LED_COUNT   = 8;
    localparam int                   BRIGHT_BITS = 8;
    localparam logic [BRIGHT_BITS-1:0] BRIGHT_MAX = 8'd255;
    localparam logic [BRIGHT_BITS-1:0] PWM_MAX    = 8'd254;
endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness register with load/decay and the PWM compare flop.
//   clock      : system clock, rising edge
//   reset      : asynchronous active-high reset
//   load       : synchronized scan bit; forces full brightness
//   decay_tick : one-cycle pulse from the shared prescaler
//   pwm_cnt    : shared free-running PWM counter
//   led        : registered LED drive, high while bright > pwm_cnt
module led_pwm_channel
    import leds_pkg::*;
#(
    parameter logic [BRIGHT_BITS-1:0] DECAY_STEP = 8'd32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   decay_tick,
    input  logic [BRIGHT_BITS-1:0] pwm_cnt,
    output logic                   led
);
    logic [BRIGHT_BITS-1:0] bright_q, bright_d;
    logic                   led_q, led_d;

    always_comb begin
        bright_d = bright_q;
        // Load outranks decay so an active LED never dims on a tick.
        if (load) begin
            bright_d = BRIGHT_MAX;
        end else if (decay_tick) begin
            bright_d = (bright_q > DECAY_STEP) ? bright_q - DECAY_STEP : '0;
        end
        // pwm_cnt tops out at 254, so 255 is always lit and 0 never is.
        led_d = (bright_q > pwm_cnt);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bright_q <= '0;
            led_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;
endmodule

// File: rtl/led_trail_pwm.sv
// LED trail effect: each LED lights fully while it is the scan position and
// then fades out in DECAY_STEP decrements, rendered with a 255-cycle PWM.
//   clock   : system clock, rising edge
//   reset   : asynchronous active-high reset
//   leds_in : asynchronous one-hot (or any) scan pattern
//   leds    : registered PWM LED drive
module led_trail_pwm
    import leds_pkg::*;
#(
    parameter logic [31:0]            DECAY_TICKS = 32'd1_000_000,
    parameter logic [BRIGHT_BITS-1:0] DECAY_STEP  = 8'd32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [LED_COUNT-1:0] leds_in,
    output logic [LED_COUNT-1:0] leds
);
    logic [LED_COUNT-1:0]   sync1_q, sync1_d;
    logic [LED_COUNT-1:0]   sync2_q, sync2_d;
    logic [31:0]            presc_q, presc_d;
    logic [BRIGHT_BITS-1:0] pwm_q, pwm_d;
    logic                   decay_tick;

    always_comb begin
        sync1_d    = leds_in;
        sync2_d    = sync1_q;
        decay_tick = (presc_q == DECAY_TICKS - 32'd1);
        presc_d    = decay_tick ? '0 : presc_q + 32'd1;
        pwm_d      = (pwm_q == PWM_MAX) ? '0 : pwm_q + 8'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            pwm_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
        end
    end

    for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
        led_pwm_channel #(
            .DECAY_STEP (DECAY_STEP)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .load       (sync2_q[i]),
            .decay_tick (decay_tick),
            .pwm_cnt    (pwm_q),
            .led        (leds[i])
        );
    end
endmodule
